// File: rtl/mac_job_dispatch.sv
// mac_job_dispatch: sequences one MAC accelerator job over a single-outstanding
// peripheral bus: acquire a job slot (with bounded retry), program the eight
// job registers, trigger, then wait for completion.
// Optional build macro MAC_JOB_DISPATCH_STATUS_POLL_EN: completion is detected
// by polling the status register instead of the evt_i pulse.
module mac_job_dispatch #(
  parameter int unsigned ID_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_RETRY = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [31:0]         job_addr_a_i,
  input  logic [31:0]         job_addr_b_i,
  input  logic [31:0]         job_addr_c_i,
  input  logic [31:0]         job_addr_d_i,
  input  logic [31:0]         job_nb_iter_i,
  input  logic [31:0]         job_len_iter_i,
  input  logic [31:0]         job_vectstride_i,
  input  logic [4:0]          job_shift_i,
  input  logic                job_simplemul_i,
  output logic                periph_req_o,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_gnt_i,
  input  logic                periph_r_valid_i,
  input  logic [31:0]         periph_r_data_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i,
  input  logic                evt_i,
  output logic                done_o,
  output logic [7:0]          done_job_id_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ACQUIRE  = 3'd1;
  localparam logic [2:0] S_ACQ_WAIT = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_TRIGGER  = 3'd4;
  localparam logic [2:0] S_WAIT_END = 3'd5;

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  logic [2:0]    r_state;
  logic          r_req;
  logic [31:0]   r_add;
  logic          r_wen;
  logic [31:0]   r_data;
  logic          r_done;
  logic          r_err;
  logic [7:0]    r_job_id;
  logic [RW-1:0] r_retry;
  logic [2:0]    r_gap;
  logic [2:0]    r_widx;
  logic [31:0]   r_desc [8];
`ifdef MAC_JOB_DISPATCH_STATUS_POLL_EN
  logic [2:0]    r_pcnt;
  logic          r_pwait;
`endif

  logic          w_soft_rst;
  logic          w_rsp_ok;
  logic [RW-1:0] w_retry_nxt;
  logic [2:0]    w_widx_nxt;
  logic [31:0]   w_nb_m1;
  logic [31:0]   w_len_m1;
  logic [31:0]   w_mode_word;
  logic          w_unused;

  assign w_soft_rst  = !rst_ni || clear_i;
  assign w_rsp_ok    = periph_r_valid_i && (periph_r_id_i == '0);
  assign w_retry_nxt = r_retry + RW'(1);
  assign w_widx_nxt  = r_widx + 3'd1;
  // Iteration counts are programmed as count-1, clamped so a zero count stays zero.
  assign w_nb_m1     = (job_nb_iter_i  == '0) ? '0 : job_nb_iter_i  - 32'd1;
  assign w_len_m1    = (job_len_iter_i == '0) ? '0 : job_len_iter_i - 32'd1;
  assign w_mode_word = {11'd0, job_shift_i, 15'd0, job_simplemul_i};
  assign w_unused    = ^{periph_r_data_i[30:8], evt_i};

  assign job_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign periph_req_o  = r_req;
  assign periph_add_o  = r_add;
  assign periph_wen_o  = r_wen;
  assign periph_data_o = r_data;
  assign periph_be_o   = 4'hF;
  assign periph_id_o   = '0;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign done_job_id_o = r_job_id;

  // Job sequencer; the request registers change only on the grant edge so the
  // bus sees a stable request until it is accepted.
  always_ff @(posedge clk_i) begin
    if (w_soft_rst) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_add    <= '0;
      r_wen    <= 1'b1;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_job_id <= '0;
      r_retry  <= '0;
      r_gap    <= '0;
      r_widx   <= '0;
      for (int unsigned i = 0; i < 8; i++) r_desc[i] <= '0;
`ifdef MAC_JOB_DISPATCH_STATUS_POLL_EN
      r_pcnt   <= '0;
      r_pwait  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (job_valid_i) begin
            r_desc[0] <= job_addr_a_i;
            r_desc[1] <= job_addr_b_i;
            r_desc[2] <= job_addr_c_i;
            r_desc[3] <= job_addr_d_i;
            r_desc[4] <= w_nb_m1;
            r_desc[5] <= w_len_m1;
            r_desc[6] <= w_mode_word;
            r_desc[7] <= job_vectstride_i;
            r_retry   <= '0;
            r_state   <= S_ACQUIRE;
            r_req     <= 1'b1;
            r_add     <= BASE_ADDR + 32'h04;
            r_wen     <= 1'b1;
            r_data    <= '0;
          end
        end
        S_ACQUIRE: begin
          if (periph_gnt_i) begin
            r_req   <= 1'b0;
            r_gap   <= '0;
            r_state <= S_ACQ_WAIT;
          end
        end
        S_ACQ_WAIT: begin
          // r_gap != 0 is the idle back-off after a busy reply; responses are not expected then.
          if (r_gap != '0) begin
            r_gap <= r_gap - 3'd1;
            if (r_gap == 3'd1) begin
              r_state <= S_ACQUIRE;
              r_req   <= 1'b1;
              r_add   <= BASE_ADDR + 32'h04;
              r_wen   <= 1'b1;
              r_data  <= '0;
            end
          end else if (w_rsp_ok) begin
            if (periph_r_data_i[31]) begin
              r_retry <= w_retry_nxt;
              if (w_retry_nxt == RW'(MAX_RETRY)) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_gap <= 3'd4;
              end
            end else begin
              r_job_id <= periph_r_data_i[7:0];
              r_state  <= S_WRITE;
              r_widx   <= '0;
              r_req    <= 1'b1;
              r_add    <= BASE_ADDR + 32'h40;
              r_wen    <= 1'b0;
              r_data   <= r_desc[0];
            end
          end
        end
        S_WRITE: begin
          if (periph_gnt_i) begin
            if (r_widx == 3'd7) begin
              r_state <= S_TRIGGER;
              r_add   <= BASE_ADDR;
              r_data  <= '0;
            end else begin
              r_widx <= w_widx_nxt;
              r_add  <= BASE_ADDR + 32'h40 + {27'd0, w_widx_nxt, 2'b00};
              r_data <= r_desc[w_widx_nxt];
            end
          end
        end
        S_TRIGGER: begin
          if (periph_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT_END;
`ifdef MAC_JOB_DISPATCH_STATUS_POLL_EN
            r_pcnt  <= 3'd7;
            r_pwait <= 1'b0;
`endif
          end
        end
        S_WAIT_END: begin
`ifdef MAC_JOB_DISPATCH_STATUS_POLL_EN
          if (r_req) begin
            if (periph_gnt_i) begin
              r_req   <= 1'b0;
              r_pwait <= 1'b1;
            end
          end else if (r_pwait) begin
            if (w_rsp_ok) begin
              r_pwait <= 1'b0;
              if (periph_r_data_i == '0) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_pcnt <= 3'd7;
              end
            end
          end else if (r_pcnt == '0) begin
            r_req  <= 1'b1;
            r_add  <= BASE_ADDR + 32'h0C;
            r_wen  <= 1'b1;
            r_data <= '0;
          end else begin
            r_pcnt <= r_pcnt - 3'd1;
          end
`else
          if (evt_i) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_dispatch.sv
// Scoreboard bench for mac_job_dispatch: job stimulus pushes the expected bus
// transactions and completion events; a bus-side monitor grants requests,
// answers reads and checks everything the DUT presents against the queue.
`timescale 1ns/1ps
module tb_mac_job_dispatch;
  localparam int unsigned TB_MAX_RETRY = 4;
  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam int K_REQ = 0, K_DONE = 1, K_ERR = 2, K_NONE = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_ni = 1'b0, clear_i = 1'b0, job_valid_i = 1'b0, job_ready_o;
  logic [31:0] job_addr_a_i = '0, job_addr_b_i = '0, job_addr_c_i = '0, job_addr_d_i = '0;
  logic [31:0] job_nb_iter_i = '0, job_len_iter_i = '0, job_vectstride_i = '0;
  logic [4:0] job_shift_i = '0;
  logic job_simplemul_i = 1'b0;
  logic periph_req_o, periph_wen_o;
  logic [31:0] periph_add_o, periph_data_o;
  logic [3:0] periph_be_o;
  logic [9:0] periph_id_o;
  logic periph_gnt_i = 1'b0, periph_r_valid_i = 1'b0;
  logic [31:0] periph_r_data_i = '0;
  logic [9:0] periph_r_id_i = '0;
  logic evt_i = 1'b0, done_o, busy_o, err_o;
  logic [7:0] done_job_id_o;

  mac_job_dispatch #(.ID_WIDTH(10), .BASE_ADDR(BASE), .MAX_RETRY(TB_MAX_RETRY)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_addr_a_i(job_addr_a_i), .job_addr_b_i(job_addr_b_i),
    .job_addr_c_i(job_addr_c_i), .job_addr_d_i(job_addr_d_i),
    .job_nb_iter_i(job_nb_iter_i), .job_len_iter_i(job_len_iter_i),
    .job_vectstride_i(job_vectstride_i), .job_shift_i(job_shift_i),
    .job_simplemul_i(job_simplemul_i),
    .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
    .periph_be_o(periph_be_o), .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
    .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
    .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i),
    .evt_i(evt_i), .done_o(done_o), .done_job_id_o(done_job_id_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] acq_list[$];
  logic [31:0] stat_list[$];
  int errors = 0, checks = 0, cyc = 0, gnt_fix = -1, wr_cnt = 0, ended = 0;
  bit trig_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic void push_exp(input int kind, input logic [31:0] addr, input logic wen,
                                   input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.wen = wen; e.data = data;
    exp_q.push_back(e);
  endfunction

  task automatic take(input string name, input int kind, output exp_t f);
    if (exp_q.size() > 0) f = exp_q.pop_front();
    else begin
      f.kind = K_NONE; f.addr = '0; f.wen = 1'b0; f.data = '0;
    end
    check(name, 64'(kind), 64'(f.kind));
  endtask

  // Bus responder and monitor: everything sampled and driven on the falling edge.
  initial begin : monitor
    exp_t f;
    bit in_req, rsp_pend, gapchk, last_wen, p_req, p_gnt, p_rst, p_wen;
    int dly, rsp_dly, busy_cyc;
    logic [31:0] p_add, p_data, rd;
    in_req = 0; rsp_pend = 0; gapchk = 0; last_wen = 1; p_req = 0; p_gnt = 0; p_rst = 0;
    p_wen = 1; dly = 0; rsp_dly = 0; busy_cyc = 0; p_add = '0; p_data = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_id_i = '0; periph_r_data_i = '0;
      if (!rst_ni || clear_i) begin
        in_req = 0; rsp_pend = 0; gapchk = 0;
      end else begin
        if (done_o) begin
          take("done_expected", K_DONE, f);
          if (f.kind == K_DONE) check("done_id", 64'(done_job_id_o), 64'(f.data[7:0]));
          ended++;
        end
        if (err_o) begin
          take("err_expected", K_ERR, f);
          gapchk = 0;
          ended++;
        end
        if (p_req && !p_gnt && p_rst) begin
          check("hold_req", 64'(periph_req_o), 64'(1));
          check("hold_addr_data", {periph_add_o, periph_data_o}, {p_add, p_data});
          check("hold_wen", 64'(periph_wen_o), 64'(p_wen));
        end
        if (rsp_pend && rsp_dly == 0) begin
          rd = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
          periph_r_valid_i = 1'b1; periph_r_id_i = '0; periph_r_data_i = rd;
          rsp_pend = 0;
          if (rd[31]) begin gapchk = 1; busy_cyc = cyc; end
        end else begin
          if (rsp_pend) rsp_dly--;
          if (!rsp_pend && !last_wen && $urandom_range(0, 5) == 0) begin
            // ID 0 reply while no read is outstanding must be ignored
            periph_r_valid_i = 1'b1; periph_r_id_i = '0; periph_r_data_i = $urandom;
          end else if ($urandom_range(0, 7) == 0) begin
            periph_r_valid_i = 1'b1; periph_r_id_i = 10'($urandom_range(1, 1023));
            periph_r_data_i = $urandom & 32'h7FFF_FF00;
          end
        end
        if (periph_req_o) begin
          if (!in_req) begin
            in_req = 1;
            dly = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(0, 3));
            if (gapchk) begin
              check("retry_gap", 64'(cyc - busy_cyc), 64'(5));
              gapchk = 0;
            end
          end
          if (dly == 0) begin
            periph_gnt_i = 1'b1;
            in_req = 0;
            take("req_expected", K_REQ, f);
            if (f.kind == K_REQ) begin
              check("req_addr", 64'(periph_add_o), 64'(f.addr));
              check("req_wen", 64'(periph_wen_o), 64'(f.wen));
              check("req_data", 64'(periph_data_o), 64'(f.data));
              check("req_be_id", 64'({periph_be_o, periph_id_o}), 64'({4'hF, 10'd0}));
            end
            last_wen = periph_wen_o;
            if (periph_wen_o) begin
              rsp_pend = 1; rsp_dly = int'($urandom_range(0, 2));
            end else if (periph_add_o == BASE) trig_seen = 1'b1;
            else wr_cnt++;
          end else dly--;
        end
      end
      p_req = periph_req_o; p_gnt = periph_gnt_i; p_rst = rst_ni && !clear_i;
      p_add = periph_add_o; p_data = periph_data_o; p_wen = periph_wen_o;
    end
  end

  // mode 0: normal completion, 1: reset during 4th write, 2: clear while waiting for the end event
  task automatic run_job(input logic [31:0] a, b, c, d, nb, len, stride,
                         input logic [4:0] sh, input logic sm, input int mode);
    int nbusy, start;
    bit fin, is_err;
    logic [7:0] id;
    logic [31:0] w [8];
    nbusy = 0; fin = 0; is_err = 0; id = '0;
    foreach (acq_list[i]) begin
      if (!fin) begin
        push_exp(K_REQ, BASE + 32'h4, 1'b1, 32'h0);
        rsp_q.push_back(acq_list[i]);
        if (acq_list[i][31]) begin
          nbusy++;
          if (nbusy == int'(TB_MAX_RETRY)) begin
            push_exp(K_ERR, '0, 1'b0, '0); fin = 1; is_err = 1;
          end
        end else begin
          id = acq_list[i][7:0]; fin = 1;
        end
      end
    end
    acq_list.delete();
    if (!is_err) begin
      w = '{a, b, c, d, (nb == 0) ? 32'd0 : nb - 32'd1, (len == 0) ? 32'd0 : len - 32'd1,
            {11'd0, sh, 15'd0, sm}, stride};
      for (int k = 0; k < 8; k++) push_exp(K_REQ, BASE + 32'h40 + 32'(4 * k), 1'b0, w[k]);
      push_exp(K_REQ, BASE, 1'b0, 32'h0);
`ifdef MAC_JOB_DISPATCH_STATUS_POLL_EN
      foreach (stat_list[i]) begin
        push_exp(K_REQ, BASE + 32'hC, 1'b1, 32'h0);
        rsp_q.push_back(stat_list[i]);
      end
`endif
      if (mode == 0) push_exp(K_DONE, '0, 1'b0, {24'd0, id});
    end
    stat_list.delete();
    check("idle_before_job", 64'({busy_o, job_ready_o}), 64'(2'b01));
    wr_cnt = 0; trig_seen = 1'b0; start = ended;
    job_addr_a_i = a; job_addr_b_i = b; job_addr_c_i = c; job_addr_d_i = d;
    job_nb_iter_i = nb; job_len_iter_i = len; job_vectstride_i = stride;
    job_shift_i = sh; job_simplemul_i = sm; job_valid_i = 1'b1;
    @(posedge clk_i) #2;
    job_valid_i = 1'b0; evt_i = 1'b1;   // stray event before the trigger
    @(posedge clk_i) #2;
    evt_i = 1'b0;
    if (mode == 1) begin
      for (int t = 0; t < 2000 && wr_cnt < 3; t++) @(posedge clk_i) #2;
      check("reach_4th_write", 64'(wr_cnt), 64'(3));
      rst_ni = 1'b0;
      @(posedge clk_i) #2;
      check("rst_mid_drop", 64'({periph_req_o, busy_o, job_ready_o, done_o, err_o}), 64'(5'b00100));
      exp_q.delete(); rsp_q.delete();
      rst_ni = 1'b1;
      repeat (3) @(posedge clk_i) #2;
    end else begin
      for (int t = 0; t < 2000 && !trig_seen && ended == start; t++) @(posedge clk_i) #2;
      if (!is_err) begin
        check("trigger_seen", 64'(trig_seen), 64'(1));
        repeat ($urandom_range(0, 5)) @(posedge clk_i) #2;
        if (mode == 2) begin
          clear_i = 1'b1;
          @(posedge clk_i) #2;
          clear_i = 1'b0;
          check("clear_idle", 64'({periph_req_o, busy_o, job_ready_o}), 64'(3'b001));
          exp_q.delete(); rsp_q.delete();
        end
        evt_i = 1'b1;
        @(posedge clk_i) #2;
        evt_i = 1'b0;
      end
      if (mode == 0) begin
        for (int t = 0; t < 2000 && ended == start; t++) @(posedge clk_i) #2;
        check("job_end", 64'(ended - start), 64'(1));
      end else repeat (4) @(posedge clk_i) #2;
      check("idle_after_job", 64'({busy_o, job_ready_o}), 64'(2'b01));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] nb, len;
    repeat (3) @(posedge clk_i) #2;
    check("rst_req_wen", 64'({periph_req_o, periph_wen_o}), 64'(2'b01));
    check("rst_add_data", {periph_add_o, periph_data_o}, 64'd0);
    check("rst_id", 64'(periph_id_o), 64'd0);
    check("rst_flags", 64'({busy_o, job_ready_o, done_o, err_o}), 64'(4'b0100));
    rst_ni = 1'b1;
    @(posedge clk_i) #2;

    acq_list = '{32'h0000_0002}; stat_list = '{32'h0};
    run_job(32'h100, 32'h200, 32'h300, 32'h400, 4, 16, 64, 5'd3, 1'b1, 0);
    gnt_fix = 5;
    acq_list = '{32'h0000_0002}; stat_list = '{32'h0};
    run_job(32'h100, 32'h200, 32'h300, 32'h400, 4, 16, 64, 5'd3, 1'b1, 0);
    gnt_fix = -1;
    acq_list = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001}; stat_list = '{32'h0};
    run_job(32'hA0, 32'hB0, 32'hC0, 32'hD0, 2, 3, 8, 5'd31, 1'b0, 0);
    acq_list = '{32'h8000_0000, 32'h8000_0011, 32'h8000_0000, 32'hFFFF_FFFF};
    run_job(32'h1, 32'h2, 32'h3, 32'h4, 5, 6, 7, 5'd1, 1'b0, 0);
    acq_list = '{32'h0000_0007}; stat_list = '{32'h0};
    run_job(32'h10, 32'h20, 32'h30, 32'h40, 9, 9, 9, 5'd2, 1'b1, 1);
    acq_list = '{32'h0000_0009}; stat_list = '{32'h1, 32'h1, 32'h0};
    run_job(32'h111, 32'h222, 32'h333, 32'h444, 0, 0, 4, 5'd0, 1'b1, 0);
    acq_list = '{32'h0000_0003}; stat_list = '{32'h0};
    run_job(32'h5, 32'h6, 32'h7, 32'h8, 1, 1, 1, 5'd4, 1'b0, 2);

    for (int j = 0; j < 10; j++) begin
      nb  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
      len = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      repeat ($urandom_range(0, 2)) acq_list.push_back(32'h8000_0000 | $urandom);
      acq_list.push_back($urandom & 32'h7FFF_FFFF);
      repeat ($urandom_range(0, 2)) stat_list.push_back(32'($urandom_range(1, 255)));
      stat_list.push_back(32'h0);
      run_job($urandom, $urandom, $urandom, $urandom, nb, len, $urandom,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(posedge clk_i) #2;
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_job_dispatch.md
MAC_JOB_DISPATCH -- requirements
Module: mac_job_dispatch

Interface
REQ-001 Parameter ID_WIDTH, default 10, width of periph transaction ID.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, MAC accelerator register base.
REQ-003 Parameter MAX_RETRY, default 255, acquire attempts before error.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 clear_i  input  1  synchronous soft clear, same effect as reset.
REQ-007 job_valid_i / job_ready_o  in/out  1/1  job descriptor handshake.
REQ-008 job_addr_a_i, job_addr_b_i, job_addr_c_i, job_addr_d_i  input  32 each  streamer base addresses.
REQ-009 job_nb_iter_i, job_len_iter_i, job_vectstride_i  input  32 each  true iteration counts and stride.
REQ-010 job_shift_i  input  5 and job_simplemul_i  input  1  engine mode.
REQ-011 periph_req_o, periph_add_o[31:0], periph_wen_o (1=read, 0=write), periph_be_o[3:0], periph_data_o[31:0], periph_id_o[ID_WIDTH-1:0]  output  request channel.
REQ-012 periph_gnt_i  input  1;  periph_r_valid_i  input  1;  periph_r_data_i  input  32;  periph_r_id_i  input  ID_WIDTH  response channel.
REQ-013 evt_i  input  1  accelerator end-of-job event pulse.
REQ-014 done_o  output  1  one-cycle job-complete pulse; done_job_id_o  output  8  job ID from acquire.
REQ-015 busy_o  output  1  high outside IDLE;  err_o  output  1  one-cycle pulse on acquire timeout.

Function
REQ-016 FSM states: IDLE, ACQUIRE, ACQ_WAIT, WRITE, TRIGGER, WAIT_END; one request outstanding at any time.
REQ-017 IDLE: job_ready_o=1; on job_valid_i&job_ready_o, register descriptor, go ACQUIRE next cycle.
REQ-018 Request rule: periph_req_o held with add/wen/data/be stable until periph_gnt_i sampled high; periph_be_o=4'hF always; periph_id_o=0.
REQ-019 ACQUIRE: read BASE_ADDR+0x04; on gnt go ACQ_WAIT.
REQ-020 ACQ_WAIT: on periph_r_valid_i with r_id==0: r_data[31]=1 -> increment retry counter, return ACQUIRE after 4 idle cycles; else latch r_data[7:0] as job ID, go WRITE.
REQ-021 Retry counter reaching MAX_RETRY: pulse err_o, discard job, return IDLE.
REQ-022 WRITE: 8 writes, word k to BASE_ADDR+0x40+4k in order: A, B, C, D, nb_iter-1, len_iter-1, {shift,15'b0,simplemul} with shift at [31:16] zero-extended, vectstride.
REQ-023 Count field value 0 written as 0 (saturate, no wrap to 32'hFFFF_FFFF).
REQ-024 Write complete at gnt; responses with wen=0 ignored; next write issued the cycle after gnt.
REQ-025 TRIGGER: write 0 to BASE_ADDR+0x00; on gnt go WAIT_END.
REQ-026 WAIT_END: evt_i -> done_o=1 with done_job_id_o, go IDLE; evt_i in any other state ignored.
REQ-027 r_valid with mismatching ID or outside ACQ_WAIT ignored.

Reset
REQ-028 Reset/clear_i: state IDLE, periph_req_o=0, add/data/id=0, wen=1, done_o=0, err_o=0, busy_o=0, retry=0, job_ready_o=1 in the following cycle.
REQ-029 Reset mid-transaction drops periph_req_o immediately; pending response ignored.

Configuration
REQ-030 Macro MAC_JOB_DISPATCH_STATUS_POLL_EN: defined -> WAIT_END ignores evt_i and polls BASE_ADDR+0x0C every 8 cycles until r_data==0, then done_o; undefined -> evt_i completion only, no poll logic.

Verification
REQ-031 Job A=0x100,B=0x200,C=0x300,D=0x400,nb=4,len=16,stride=64,shift=3,simplemul=1; acquire returns 0x02 -> 8 writes values 0x100,0x200,0x300,0x400,3,15,0x0003_0001,64 then trigger; evt -> done_o, ID 2.
REQ-032 gnt withheld 5 cycles per request -> req/add/data stable throughout; write order unchanged.
REQ-033 Acquire returns 0x8000_0000 three times then 0x01 -> 4 reads with 4-cycle gaps, job ID 1.
REQ-034 MAX_RETRY=2, acquire always busy -> err_o pulse after 2nd response, back to IDLE, no writes.
REQ-035 rst_ni low during 4th write -> next cycle req=0, IDLE; later job runs cleanly.
REQ-036 nb_iter=0 -> word 4 written as 0; with POLL_EN, status 1,1,0 -> done_o after 3rd poll.
